// File: rtl/jg_judge_seq.sv
// jg_judge_seq: registered, streaming X/Y sample judge.
// Each accepted sample yields X (sample >= THRESH) and Y (all-zeros/all-ones)
// flags. Mode 1 passes them through a per-flag consecutive-sample debouncer.
// Results sit in a one-entry valid/ready stage and are tallied by saturating
// event counters when they transfer.
//
// Output stage FSM:
//   state | meaning
//   EMPTY | no result held, out_valid=0, always ready for a sample
//   FULL  | x/y hold a result, out_valid=1, waiting for out_ready
module jg_judge_seq #(
    parameter int WIDTH  = 3,
    parameter int THRESH = 5,
    parameter int HOLD   = 3,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] abc,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             x,
    output logic             y,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] x_count,
    output logic [CNT_W-1:0] y_count
);

    localparam int RUN_W = $clog2(HOLD + 1);
    localparam logic [RUN_W-1:0] HOLD_V  = RUN_W'(HOLD);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam logic [WIDTH-1:0] THR_V   = WIDTH'(THRESH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state, state_nxt;

    logic accept, transfer;
    logic x_raw, y_raw;
    logic db_x, db_y, db_x_nxt, db_y_nxt;
    logic [RUN_W-1:0] run_x, run_y, run_x_nxt, run_y_nxt;
    logic x_load, y_load;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign transfer = out_valid && out_ready;

    assign x_raw = (abc >= THR_V);
    assign y_raw = (abc == '0) || (abc == '1);

    // Debouncer next state: a flag flips only after HOLD consecutive disagreeing samples
    always_comb begin
        db_x_nxt  = db_x;
        run_x_nxt = run_x;
        if (x_raw == db_x) begin
            run_x_nxt = '0;
        end else if ((run_x + RUN_ONE) == HOLD_V) begin
            db_x_nxt  = x_raw;
            run_x_nxt = '0;
        end else begin
            run_x_nxt = run_x + RUN_ONE;
        end

        db_y_nxt  = db_y;
        run_y_nxt = run_y;
        if (y_raw == db_y) begin
            run_y_nxt = '0;
        end else if ((run_y + RUN_ONE) == HOLD_V) begin
            db_y_nxt  = y_raw;
            run_y_nxt = '0;
        end else begin
            run_y_nxt = run_y + RUN_ONE;
        end
    end

    // Debouncer state advances on every accept, independent of mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_x  <= 1'b0;
            db_y  <= 1'b0;
            run_x <= '0;
            run_y <= '0;
        end else if (accept) begin
            db_x  <= db_x_nxt;
            db_y  <= db_y_nxt;
            run_x <= run_x_nxt;
            run_y <= run_y_nxt;
        end
    end

    // Mode selects raw flags or the post-update debounced flags
    assign x_load = mode ? db_x_nxt : x_raw;
    assign y_load = mode ? db_y_nxt : y_raw;

    // Output stage state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Output stage next state: accept always fills, a bare transfer empties
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL:  if (transfer && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Output stage outputs
    always_comb begin
        out_valid = (state == FULL);
    end

    // Held result: loaded on accept, stable otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= 1'b0;
            y <= 1'b0;
        end else if (accept) begin
            x <= x_load;
            y <= y_load;
        end
    end

    // Saturating event counters; clear beats a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_count <= '0;
            y_count <= '0;
        end else if (clr_cnt) begin
            x_count <= '0;
            y_count <= '0;
        end else if (transfer) begin
            if (x && (x_count != '1)) x_count <= x_count + CNT_ONE;
            if (y && (y_count != '1)) y_count <= y_count + CNT_ONE;
        end
    end

endmodule

// File: doc/jg_judge_seq.md
# jg_judge_seq

- Registered, streaming, parametrised successor to the team's combinational 3-bit X/Y judge.
- Each accepted WIDTH-bit sample produces two raw flags:
  - X: sample ≥ THRESH.
  - Y: sample is all-zeros or all-ones.
- Flags pass through an optional per-flag consecutive-sample debouncer, a one-entry valid/ready output stage, and saturating event counters.
- Sits between a sample source and a downstream consumer; with WIDTH=3 and THRESH=5, mode 0 reproduces the original truth table with one cycle of latency.

## Interface
Parameters:
- WIDTH, 3, sample width; must be ≥ 2.
- THRESH, 5, X threshold; must be < 2^WIDTH.
- HOLD, 3, consecutive disagreeing samples needed to flip a debounced flag; must be ≥ 1.
- CNT_W, 8, event counter width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample; combinational: !out_valid || out_ready.
- abc  in  WIDTH  sample value, unsigned.
- mode  in  1  0 = raw flags, 1 = debounced flags; sampled with each accepted sample.
- out_valid  out  1  x/y hold a result.
- out_ready  in  1  consumer takes result.
- x  out  1  X flag of the held result.
- y  out  1  Y flag of the held result.
- clr_cnt  in  1  synchronous clear of both counters.
- x_count  out  CNT_W  number of transferred results with x=1, saturating.
- y_count  out  CNT_W  number of transferred results with y=1, saturating.

## Operation
**Accept and transfer**
- Accept: in_valid && in_ready at a clock edge.
- Transfer: out_valid && out_ready at a clock edge.

**Raw flags**
- x_raw = (abc ≥ THRESH), unsigned compare.
- y_raw = (abc == 0) || (abc == 2^WIDTH−1).

**Debouncer (per flag, state db_x / db_y plus run counter)**
- Width of each run counter: clog2(HOLD+1).
- Updates on every accept, regardless of mode.
- raw == db: run ← 0.
- raw != db and run+1 == HOLD: db ← raw, run ← 0.
- Otherwise: run ← run+1.
- HOLD=1 makes db equal to raw after every accept.
- No update on cycles without an accept.

**Output stage (two states)**
- EMPTY: out_valid=0.
  - Accept → FULL; x/y loaded.
- FULL: out_valid=1.
  - Accept (only possible when out_ready=1) → stay FULL with a new x/y.
  - Transfer with no accept → EMPTY.
  - No transfer → hold x/y stable.
- Loaded value: mode=0 loads x_raw/y_raw; mode=1 loads the post-update db_x/db_y.

**Counters**
- Each transfer increments x_count if x=1 and y_count if y=1.
- Both counters saturate at 2^CNT_W−1.
- clr_cnt forces both to 0 and wins over a same-cycle increment.

**Reset (asynchronous, immediate)**
- out_valid=0, x=0, y=0, x_count=0, y_count=0, db_x=db_y=0, both run counters 0.
- in_ready=1 while rst is held and after release.

## Timing
- Latency: sample accepted at edge k → out_valid, x, y valid after edge k.
- Throughput: one sample per cycle when out_ready stays high.
- Backpressure:
  - out_valid=1 and out_ready=0 → in_ready=0 in the same cycle.
  - x/y stay stable until transfer.
  - Debouncer does not advance while backpressured.
- Simultaneous transfer and accept: the old result is counted and the new result is loaded at the same edge; no bubble.
- Counter update for a transfer at edge k is visible after edge k.
- rst asserted mid-stream clears all outputs without waiting for a clock edge; the in-flight result is discarded and not counted.
- Mode switch takes effect on the next accepted sample; the debouncer state is continuous across switches.

## Test plan
1. **Mode 0 sweep.** WIDTH=3, THRESH=5, out_ready=1; abc=0..7 back-to-back.
   - Required (x,y) one cycle after each accept: 01,00,00,00,00,10,10,11.
   - out_valid stays high throughout.
2. **Backpressure.** Result for abc=5 held with out_ready=0 for 3 cycles, abc=7 presented with in_valid=1.
   - in_ready=0 and (x,y)=10 stable for those 3 cycles.
   - Raise out_ready → transfer of 10, then (x,y)=11 loaded on the same edge.
3. **Debounce.** mode=1, HOLD=3; accept samples 7,7,0,7,7,7.
   - x sequence: 0,0,0,0,0,1 (the 0 sample resets the run).
   - y sequence: 0,0,1,1,1,1.
4. **Counters.** CNT_W=8; 300 transfers of abc=6 in mode 0.
   - x_count=255 (saturated), y_count=0.
   - Assert clr_cnt on the same edge as a transfer of abc=7 → both counters read 0 afterwards.
5. **Async reset mid-stream.** Reset while out_valid=1 and db run counters are nonzero.
   - out_valid, x, y, x_count, y_count all 0 before the next clock edge.
   - After release, mode=1 with abc=7 repeated: x rises only on the 3rd accepted sample.
